// File: rtl/fifo_frame_writer.sv
// fifo_frame_writer: write-side framer for the async FIFO.
// Buffers one upstream frame (up to MAX_LEN words), then writes a header word
// carrying the length and a continuation flag, followed by the payload.
// FIFO word bit WIDTH marks headers (1) versus payload (0).
module fifo_frame_writer #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MAX_LEN = 16
) (
   input  logic             wr_clk,
   input  logic             wr_reset,
   input  logic             s_valid,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_last,
   output logic             s_ready,
   input  logic             fifo_full,
   output logic             fifo_wr_en,
   output logic [WIDTH:0]   fifo_wr_data,
   output logic [15:0]      frames_sent
);

   localparam int unsigned LW = $clog2(MAX_LEN + 1);
   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

   // The length field must fit below the continuation bit of the header.
   generate
      if (LW > WIDTH - 1) begin : g_bad_width
         $error("fifo_frame_writer: length field does not fit in WIDTH-1 bits");
      end
   endgenerate

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      HDR     = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [LW-1:0]    cnt_q, cnt_d;
   logic [LW-1:0]    idx_q, idx_d;
   logic [LW-1:0]    len_q, len_d;
   logic             cont_q, cont_d;
   logic [15:0]      frames_sent_q, frames_sent_d;

   logic [WIDTH-1:0] buf_mem [MAX_LEN];
   logic             buf_we;
   logic [LW-1:0]    cnt_inc;
   logic [WIDTH:0]   hdr_word;

   // Next-state and datapath updates for the framer.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      len_d         = len_q;
      cont_d        = cont_q;
      frames_sent_d = frames_sent_q;
      buf_we        = 1'b0;
      cnt_inc       = cnt_q + LW'(1);
      unique case (state_q)
         COLLECT: begin
            if (s_valid) begin
               buf_we = 1'b1;
               cnt_d  = cnt_inc;
               // Close on end of message, or when the buffer fills mid-message.
               if (s_last || (cnt_inc == MAX_LEN_L)) begin
                  len_d   = cnt_inc;
                  cont_d  = !s_last;
                  state_d = HDR;
               end
            end
         end
         HDR: begin
            if (!fifo_full) begin
               idx_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!fifo_full) begin
               idx_d = idx_q + LW'(1);
               if (idx_q == len_q - LW'(1)) begin
                  frames_sent_d = frames_sent_q + 16'd1;
                  cnt_d         = '0;
                  state_d       = COLLECT;
               end
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge wr_clk or negedge wr_reset) begin
      if (!wr_reset) begin
         state_q       <= COLLECT;
         cnt_q         <= '0;
         idx_q         <= '0;
         len_q         <= '0;
         cont_q        <= 1'b0;
         frames_sent_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         len_q         <= len_d;
         cont_q        <= cont_d;
         frames_sent_q <= frames_sent_d;
      end
   end

   // Frame buffer; contents are don't-care after reset.
   always_ff @(posedge wr_clk) begin
      if (buf_we) begin
         buf_mem[cnt_q[AW-1:0]] <= s_data;
      end
   end

   // Header word: marker, continuation flag, zero-extended length.
   always_comb begin
      hdr_word            = '0;
      hdr_word[WIDTH]     = 1'b1;
      hdr_word[WIDTH-1]   = cont_q;
      hdr_word[LW-1:0]    = len_q;
   end

   // Handshake and FIFO write port, combinational from state.
   always_comb begin
      s_ready      = 1'b0;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      unique case (state_q)
         COLLECT: s_ready = 1'b1;
         HDR: begin
            fifo_wr_en   = !fifo_full;
            fifo_wr_data = hdr_word;
         end
         DRAIN: begin
            fifo_wr_en   = !fifo_full;
            fifo_wr_data = {1'b0, buf_mem[idx_q[AW-1:0]]};
         end
         default: s_ready = 1'b0;
      endcase
   end

   assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Scoreboard bench for fifo_frame_writer: expected FIFO words are queued when
// a message is driven and checked as the DUT writes them.
module tb_fifo_frame_writer;

   localparam int WIDTH   = 8;
   localparam int MAX_LEN = 16;

   logic             wr_clk;
   logic             wr_reset;
   logic             s_valid;
   logic [WIDTH-1:0] s_data;
   logic             s_last;
   logic             s_ready;
   logic             fifo_full;
   logic             fifo_wr_en;
   logic [WIDTH:0]   fifo_wr_data;
   logic [15:0]      frames_sent;

   fifo_frame_writer #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
      .wr_clk       (wr_clk),
      .wr_reset     (wr_reset),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_last       (s_last),
      .s_ready      (s_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .frames_sent  (frames_sent)
   );

   int             n_vec = 0;
   int             n_err = 0;
   logic [WIDTH:0] exp_q [$];
   logic [15:0]    exp_frames = '0;
   int             wr_count = 0;
   int             low_cycles = 0;
   logic           prev_stall = 1'b0;
   logic [WIDTH:0] prev_data = '0;

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference framing: split into MAX_LEN chunks, header then payload.
   task automatic push_expected(input int n, input logic [7:0] first, input logic [7:0] step);
      int rem;
      int pos;
      int len;
      logic [WIDTH:0] hdr;
      logic [7:0] d;
      rem = n;
      pos = 0;
      while (rem > 0) begin
         len = (rem > MAX_LEN) ? MAX_LEN : rem;
         hdr = 9'h100 | ((rem > MAX_LEN) ? 9'h080 : 9'h000) | 9'(len);
         exp_q.push_back(hdr);
         for (int k = 0; k < len; k++) begin
            d = first + 8'(pos + k) * step;
            exp_q.push_back({1'b0, d});
         end
         pos += len;
         rem -= len;
         exp_frames = exp_frames + 16'd1;
      end
   endtask

   task automatic send_msg(input int n, input logic [7:0] first, input logic [7:0] step);
      int   guard;
      logic accepted;
      push_expected(n, first, step);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = first + 8'(i) * step;
         s_last  = (i == n - 1);
         guard = 0;
         accepted = 1'b0;
         while (!accepted && guard < 300) begin
            @(negedge wr_clk);
            accepted = s_ready;
            @(posedge wr_clk);
            #1;
            guard++;
         end
         if (!accepted) check_eq("accept_timeout", 32'(accepted), 32'd1);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      do begin
         @(negedge wr_clk);
         guard++;
      end while ((exp_q.size() != 0 || !s_ready) && guard < 400);
      check_eq("drain_done", 32'(exp_q.size()), 32'd0);
      @(posedge wr_clk);
      #1;
   endtask

   // Monitor: scoreboard compare, full/enable rule, stall stability.
   always @(negedge wr_clk) begin
      logic [WIDTH:0] e;
      if (!wr_reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check_eq("stall_hold", 32'(fifo_wr_data), 32'(prev_data));
         if (fifo_full) check_eq("wr_en_while_full", 32'(fifo_wr_en), 32'd0);
         if (!s_ready) low_cycles++;
         if (fifo_wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
               check_eq("unexpected_write", 32'(fifo_wr_data), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check_eq("fifo_word", 32'(fifo_wr_data), 32'(e));
            end
         end
         prev_stall = fifo_full && !s_ready;
         prev_data  = fifo_wr_data;
      end
   end

   initial begin
      int w0;
      int guard;
      wr_reset  = 1'b0;
      s_valid   = 1'b0;
      s_data    = '0;
      s_last    = 1'b0;
      fifo_full = 1'b0;
      repeat (3) @(posedge wr_clk);
      #1;
      check_eq("rst_s_ready", 32'(s_ready), 32'd1);
      check_eq("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check_eq("rst_wr_data", 32'(fifo_wr_data), 32'd0);
      check_eq("rst_frames", 32'(frames_sent), 32'd0);
      @(negedge wr_clk);
      wr_reset = 1'b1;
      @(posedge wr_clk);
      #1;

      // Single 3-word frame.
      low_cycles = 0;
      send_msg(3, 8'h11, 8'h11);
      wait_idle();
      check_eq("single_frames", 32'(frames_sent), 32'(exp_frames));
      check_eq("single_ready_low", 32'(low_cycles), 32'd4);

      // 20-word message split into 16 + 4.
      send_msg(20, 8'h01, 8'h01);
      wait_idle();
      check_eq("split_frames", 32'(frames_sent), 32'(exp_frames));

      // Backpressure: 5 cycles full in HDR, then alternate in DRAIN.
      send_msg(5, 8'h40, 8'h03);
      fifo_full = 1'b1;
      repeat (5) begin
         @(posedge wr_clk);
         #1;
      end
      fifo_full = 1'b0;
      guard = 0;
      while (!s_ready && guard < 40) begin
         @(posedge wr_clk);
         #1;
         fifo_full = ~fifo_full;
         guard++;
      end
      fifo_full = 1'b0;
      wait_idle();
      check_eq("bp_frames", 32'(frames_sent), 32'(exp_frames));

      // Exactly MAX_LEN words with last: single frame, cont clear.
      send_msg(16, 8'h80, 8'h05);
      wait_idle();
      repeat (5) @(posedge wr_clk);
      #1;
      check_eq("exact_frames", 32'(frames_sent), 32'(exp_frames));

      // Reset after header + 2 payload writes of a 5-word frame.
      send_msg(5, 8'hC0, 8'h01);
      w0 = wr_count;
      guard = 0;
      while (wr_count < w0 + 3 && guard < 50) begin
         @(negedge wr_clk);
         guard++;
      end
      check_eq("mid_drain_writes", 32'(wr_count - w0), 32'd3);
      @(posedge wr_clk);
      #1;
      wr_reset = 1'b0;
      #1;
      check_eq("async_rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check_eq("async_rst_frames", 32'(frames_sent), 32'd0);
      exp_q.delete();
      exp_frames = '0;
      @(negedge wr_clk);
      wr_reset = 1'b1;
      @(posedge wr_clk);
      #1;
      check_eq("post_rst_ready", 32'(s_ready), 32'd1);
      send_msg(1, 8'hAA, 8'h00);
      wait_idle();
      check_eq("post_rst_frames", 32'(frames_sent), 32'(exp_frames));

      // Counter wrap from 0xFFFF.
      force dut.frames_sent_q = 16'hFFFF;
      @(posedge wr_clk);
      #1;
      release dut.frames_sent_q;
      exp_frames = 16'hFFFF;
      check_eq("wrap_preload", 32'(frames_sent), 32'(exp_frames));
      send_msg(1, 8'h5A, 8'h00);
      wait_idle();
      check_eq("wrap_frames", 32'(frames_sent), 32'(exp_frames));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time limit so the bench always ends.
   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "timeout");
   end

endmodule
